// File: rtl/ultrasonic_trig_out_pkg.sv
// Shared definitions for the ultrasonic trigger generator: register map,
// bit positions, FSM encoding and the terminal-count helper.
package ultrasonic_trig_out_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_WIDTH  = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CONTROL bits
  localparam int CTRL_START = 0;
  localparam int CTRL_AUTO  = 1;

  // STATUS bits
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } trig_state_t;

  // Last count value of an n-cycle interval. A zero length is treated as one
  // cycle, so the compare value never underflows and the counter never wraps.
  function automatic logic [31:0] term_count(input logic [31:0] n);
    return (n == 32'd0) ? 32'd0 : n - 32'd1;
  endfunction

endpackage

// File: rtl/ultrasonic_trig_timer.sv
// Trigger pulse sequencer: latches width/period at each pulse start, drives
// the registered trigger line and repeats while auto mode stays enabled.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | trigger low, waiting for a start request or auto enable
//   PULSE   | trigger high, counting up to the latched width
//   HOLDOFF | trigger low, counting to the latched period before re-arming
module ultrasonic_trig_timer
  import ultrasonic_trig_out_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        auto_en,
  input  logic [31:0] width,
  input  logic [31:0] period,
  output logic        trig,
  output logic        busy,
  output logic        done_pulse
);

  trig_state_t state;
  trig_state_t state_nxt;

  logic [31:0] cnt;
  logic [31:0] w_lat;
  logic [31:0] p_lat;
  logic        load;
  logic        pulse_end;
  logic        hold_end;
  logic        trig_nxt;

  // cnt is measured from the pulse start, so the holdoff compare against
  // p_lat-1 yields the full period; when p_lat <= w_lat the compare is
  // already true on HOLDOFF entry, giving the 1-clock minimum low time.
  assign pulse_end = (state == PULSE) && (cnt == term_count(w_lat));
  assign hold_end  = (state == HOLDOFF) && auto_en && (cnt >= term_count(p_lat));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start || auto_en) begin
          state_nxt = PULSE;
        end
      end
      PULSE: begin
        if (pulse_end) begin
          state_nxt = auto_en ? HOLDOFF : IDLE;
        end
      end
      HOLDOFF: begin
        if (!auto_en) begin
          state_nxt = IDLE;
        end else if (hold_end) begin
          state_nxt = PULSE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath-control decode
  always_comb begin
    busy       = (state != IDLE);
    done_pulse = pulse_end;
    load       = ((state == IDLE) && (start || auto_en)) || hold_end;
    trig_nxt   = trig;
    if (load) begin
      trig_nxt = 1'b1;
    end else if (pulse_end) begin
      trig_nxt = 1'b0;
    end
  end

  // Counter, latched settings and registered trigger output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= 32'd0;
      w_lat <= 32'd1;
      p_lat <= 32'd0;
      trig  <= 1'b0;
    end else begin
      trig <= trig_nxt;
      if (load) begin
        w_lat <= (width == 32'd0) ? 32'd1 : width;
        p_lat <= period;
        cnt   <= 32'd0;
      end else if (state != IDLE) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/ultrasonic_trig_out.sv
// Avalon-MM slave for the ultrasonic ranger TRIG pin: register file, read
// mux and status tracking around the trigger sequencer.
module ultrasonic_trig_out
  import ultrasonic_trig_out_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter logic [31:0] DEF_WIDTH  = 32'd500,
  parameter logic [31:0] DEF_PERIOD = 32'd3000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port
);

  // CLK_HZ only documents the timebase behind the default width/period.
  if (CLK_HZ == 0) begin : g_bad_clk_hz
    $error("CLK_HZ must be nonzero");
  end

  logic        wr_en;
  logic        rd_en;
  logic        start_q;
  logic        auto_en;
  logic [31:0] width_reg;
  logic [31:0] period_reg;
  logic        done_flag;
  logic [15:0] pulse_cnt;
  logic        busy;
  logic        done_pulse;
  logic        trig;
  logic [31:0] rd_mux;

  assign wr_en = chipselect && !write_n;
  assign rd_en = chipselect && write_n;

  // Configuration registers; START is captured as a one-cycle request so it
  // reaches the sequencer on the same edge as an AUTO bit from the same write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q    <= 1'b0;
      auto_en    <= 1'b0;
      width_reg  <= DEF_WIDTH;
      period_reg <= DEF_PERIOD;
    end else begin
      start_q <= wr_en && (address == ADDR_CTRL) && writedata[CTRL_START];
      if (wr_en) begin
        case (address)
          ADDR_CTRL:   auto_en    <= writedata[CTRL_AUTO];
          ADDR_WIDTH:  width_reg  <= writedata;
          ADDR_PERIOD: period_reg <= writedata;
          default:     ;
        endcase
      end
    end
  end

  // Sticky DONE (hardware set beats software clear) and completed-pulse count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_flag <= 1'b0;
      pulse_cnt <= 16'd0;
    end else begin
      if (done_pulse) begin
        done_flag <= 1'b1;
      end else if (wr_en && (address == ADDR_STATUS) && writedata[STAT_DONE]) begin
        done_flag <= 1'b0;
      end
      if (done_pulse) begin
        pulse_cnt <= pulse_cnt + 16'd1;
      end
    end
  end

  // Read mux; unused bits read as zero and START always reads back 0
  always_comb begin
    rd_mux = 32'd0;
    case (address)
      ADDR_CTRL:   rd_mux[CTRL_AUTO] = auto_en;
      ADDR_WIDTH:  rd_mux = width_reg;
      ADDR_PERIOD: rd_mux = period_reg;
      ADDR_STATUS: begin
        rd_mux[STAT_BUSY]             = busy;
        rd_mux[STAT_DONE]             = done_flag;
        rd_mux[STAT_CNT_LSB +: 16]    = pulse_cnt;
      end
      default:     rd_mux = 32'd0;
    endcase
  end

  // Registered read data, one cycle of read latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else if (rd_en) begin
      readdata <= rd_mux;
    end
  end

  ultrasonic_trig_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start_q),
    .auto_en    (auto_en),
    .width      (width_reg),
    .period     (period_reg),
    .trig       (trig),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

  assign out_port = trig;

endmodule
